pong_ctrl: RTL and testbench

PONG_CTRL -- requirements
Module: pong_ctrl

---
 rtl/pong_pkg.sv | 39 +++
 rtl/frame_timer.sv | 43 ++++
 rtl/pong_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_pong_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared types and constants for the pong game controller.
//   state_t      : FSM state encoding (also driven out on pong_ctrl.state)
//   WIN_*        : winner output codes
//   DEF_*        : default timing / scoring parameters
//   sat_inc      : score increment that saturates at a limit
// -----------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_POINT = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam int DEF_FRAME_DIV    = 833333;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_WIN_SCORE    = 7;

    // Increment a 4-bit score, never going past lim.
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        logic [3:0] r;
        if (v >= lim) begin
            r = lim;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Free-running divider counting 0..DIV-1; tick is high for exactly the cycle
// on which the count has just wrapped back to 0.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   tick  out one-cycle frame pulse (registered)
// -----------------------------------------------------------------------------
module frame_timer
    import pong_pkg::*;
#(
    parameter int DIV = DEF_FRAME_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter; the tick register marks the wrap to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + ONE;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/pong_ctrl.sv
// -----------------------------------------------------------------------------
// pong_ctrl
// Game-flow controller for pong: serve delay, per-frame physics step
// handshake, scoring, winner detection and frame-overrun detection.
// Ports:
//   CLOCK_50   in  system clock
//   rst_n      in  asynchronous active-low reset
//   start      in  level; rising edge starts/restarts a game from IDLE/OVER
//   pause      in  level; freezes serve countdown and new steps while high
//   step_req   out physics step request, held until step_done
//   step_done  in  physics step complete (qualifies miss_l/miss_r)
//   miss_l     in  ball passed the left paddle this step
//   miss_r     in  ball passed the right paddle this step
//   ball_reset out one-cycle recentre pulse
//   serve_dir  out 0 = serve left, 1 = serve right
//   p1_score   out left player score
//   p2_score   out right player score
//   winner     out 00 none, 01 p1, 10 p2
//   state      out current FSM state code
//   frame_tick out one-cycle frame pulse
//   overrun    out sticky: a frame tick arrived while a step was outstanding
// All outputs are registered.
// -----------------------------------------------------------------------------
module pong_ctrl
    import pong_pkg::*;
#(
    parameter int FRAME_DIV    = DEF_FRAME_DIV,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int WIN_SCORE    = DEF_WIN_SCORE
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    output logic       step_req,
    input  logic       step_done,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] winner,
    output logic [2:0] state,
    output logic       frame_tick,
    output logic       overrun
);

    localparam int            SC_W       = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [SC_W-1:0] SERVE_LAST = SC_W'(SERVE_FRAMES - 1);
    localparam logic [SC_W-1:0] SC_ONE     = SC_W'(1);
    localparam logic [3:0]    WIN_S      = 4'(WIN_SCORE);

    logic            tick_s;
    logic            start_rise_s;

    state_t          state_r,      state_nxt_s;
    logic [SC_W-1:0] serve_cnt_r,  serve_cnt_nxt_s;
    logic [3:0]      p1_r,         p1_nxt_s;
    logic [3:0]      p2_r,         p2_nxt_s;
    logic [1:0]      winner_r,     winner_nxt_s;
    logic            serve_dir_r,  serve_dir_nxt_s;
    logic            step_req_r,   step_req_nxt_s;
    logic            ball_reset_r, ball_reset_nxt_s;
    logic            overrun_r,    overrun_nxt_s;
    logic            start_q_r;

    frame_timer #(
        .DIV (FRAME_DIV)
    ) u_frame_timer (
        .clk   (CLOCK_50),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    // History resets to 1 so a start held through reset does not look like an edge.
    assign start_rise_s = start & ~start_q_r;

    // Start edge-detector history.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            start_q_r <= 1'b1;
        end else begin
            start_q_r <= start;
        end
    end

    // Next-state and next-output logic for the game FSM.
    always_comb begin
        state_nxt_s      = state_r;
        serve_cnt_nxt_s  = serve_cnt_r;
        p1_nxt_s         = p1_r;
        p2_nxt_s         = p2_r;
        winner_nxt_s     = winner_r;
        serve_dir_nxt_s  = serve_dir_r;
        step_req_nxt_s   = 1'b0;
        ball_reset_nxt_s = 1'b0;
        overrun_nxt_s    = overrun_r;

        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (start_rise_s) begin
                    p1_nxt_s         = 4'd0;
                    p2_nxt_s         = 4'd0;
                    winner_nxt_s     = WIN_NONE;
                    serve_dir_nxt_s  = 1'b0;
                    serve_cnt_nxt_s  = '0;
                    ball_reset_nxt_s = 1'b1;
                    state_nxt_s      = ST_SERVE;
                end else begin
                    state_nxt_s      = state_r;
                end
            end

            ST_SERVE: begin
                // Only unpaused frames advance the serve countdown.
                if (tick_s && !pause) begin
                    if (serve_cnt_r == SERVE_LAST) begin
                        serve_cnt_nxt_s = '0;
                        state_nxt_s     = ST_PLAY;
                    end else begin
                        serve_cnt_nxt_s = serve_cnt_r + SC_ONE;
                    end
                end else begin
                    serve_cnt_nxt_s = serve_cnt_r;
                end
            end

            ST_PLAY: begin
                if (tick_s && !pause) begin
                    step_req_nxt_s = 1'b1;
                    state_nxt_s    = ST_WAIT;
                end else begin
                    step_req_nxt_s = 1'b0;
                end
            end

            ST_WAIT: begin
                // A frame arriving while the step is still outstanding is lost.
                if (tick_s) begin
                    overrun_nxt_s = 1'b1;
                end else begin
                    overrun_nxt_s = overrun_r;
                end

                // Pause is deliberately not consulted: the handshake always completes.
                if (step_done) begin
                    step_req_nxt_s = 1'b0;
                    case ({miss_l, miss_r})
                        2'b00: begin
                            state_nxt_s = ST_PLAY;
                        end
                        2'b10: begin
                            p2_nxt_s        = sat_inc(p2_r, WIN_S);
                            serve_dir_nxt_s = 1'b0;
                            state_nxt_s     = ST_POINT;
                        end
                        2'b01: begin
                            p1_nxt_s        = sat_inc(p1_r, WIN_S);
                            serve_dir_nxt_s = 1'b1;
                            state_nxt_s     = ST_POINT;
                        end
                        default: begin
                            // Simultaneous miss: replay the serve, no point awarded.
                            ball_reset_nxt_s = 1'b1;
                            serve_cnt_nxt_s  = '0;
                            state_nxt_s      = ST_SERVE;
                        end
                    endcase
                end else begin
                    step_req_nxt_s = 1'b1;
                end
            end

            ST_POINT: begin
                if (p1_r == WIN_S) begin
                    winner_nxt_s = WIN_P1;
                    state_nxt_s  = ST_OVER;
                end else if (p2_r == WIN_S) begin
                    winner_nxt_s = WIN_P2;
                    state_nxt_s  = ST_OVER;
                end else begin
                    ball_reset_nxt_s = 1'b1;
                    serve_cnt_nxt_s  = '0;
                    state_nxt_s      = ST_SERVE;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            serve_cnt_r  <= '0;
            p1_r         <= 4'd0;
            p2_r         <= 4'd0;
            winner_r     <= WIN_NONE;
            serve_dir_r  <= 1'b0;
            step_req_r   <= 1'b0;
            ball_reset_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            serve_cnt_r  <= serve_cnt_nxt_s;
            p1_r         <= p1_nxt_s;
            p2_r         <= p2_nxt_s;
            winner_r     <= winner_nxt_s;
            serve_dir_r  <= serve_dir_nxt_s;
            step_req_r   <= step_req_nxt_s;
            ball_reset_r <= ball_reset_nxt_s;
            overrun_r    <= overrun_nxt_s;
        end
    end

    assign step_req   = step_req_r;
    assign ball_reset = ball_reset_r;
    assign serve_dir  = serve_dir_r;
    assign p1_score   = p1_r;
    assign p2_score   = p2_r;
    assign winner     = winner_r;
    assign state      = state_r;
    assign frame_tick = tick_s;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_pong_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_ctrl
// Self-checking bench for pong_ctrl with FRAME_DIV=4, SERVE_FRAMES=2,
// WIN_SCORE=3. Expected output snapshots are pushed to a queue when a step
// result is driven and popped as the DUT responds.
// Snapshot packing: {state[2:0], p1[3:0], p2[3:0], winner[1:0], serve_dir,
//                    ball_reset, step_req}
// -----------------------------------------------------------------------------
module tb_pong_ctrl;

    logic       CLOCK_50;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic       step_req;
    logic       step_done;
    logic       miss_l;
    logic       miss_r;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] winner;
    logic [2:0] state;
    logic       frame_tick;
    logic       overrun;

    int vectors;
    int miscompares;

    logic [15:0] sb[$];

    // Reference game model
    logic [3:0] m_p1;
    logic [3:0] m_p2;
    logic [1:0] m_win;
    logic       m_dir;

    pong_ctrl #(
        .FRAME_DIV    (4),
        .SERVE_FRAMES (2),
        .WIN_SCORE    (3)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .step_req   (step_req),
        .step_done  (step_done),
        .miss_l     (miss_l),
        .miss_r     (miss_r),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .winner     (winner),
        .state      (state),
        .frame_tick (frame_tick),
        .overrun    (overrun)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] pk(input logic [2:0] st, input logic [3:0] a,
                                       input logic [3:0] b, input logic [1:0] w,
                                       input logic d, input logic br, input logic sr);
        return {st, a, b, w, d, br, sr};
    endfunction

    function automatic logic [15:0] snap();
        return {state, p1_score, p2_score, winner, serve_dir, ball_reset, step_req};
    endfunction

    task automatic cyc();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; start = 1'b0; pause = 1'b0;
        step_done = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        m_p1 = 4'd0; m_p2 = 4'd0; m_win = 2'b00; m_dir = 1'b0;
        sb.delete();
    endtask

    task automatic start_game();
        start = 1'b1;
        cyc();
        start = 1'b0;
        m_p1 = 4'd0; m_p2 = 4'd0; m_win = 2'b00; m_dir = 1'b0;
    endtask

    task automatic wait_req(input int budget, output bit ok);
        int n;
        n = 0;
        while (step_req !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        ok = (step_req === 1'b1);
    endtask

    // Complete one step with the given misses; push expected snapshots.
    task automatic do_step(input logic ml, input logic mr, output bit ok);
        wait_req(60, ok);
        if (ok) begin
            step_done = 1'b1; miss_l = ml; miss_r = mr;
            if (ml && mr) begin
                sb.push_back(pk(3'd1, m_p1, m_p2, m_win, m_dir, 1'b1, 1'b0));
            end else if (ml) begin
                if (m_p2 < 4'd3) m_p2 = m_p2 + 4'd1;
                m_dir = 1'b0;
                sb.push_back(pk(3'd4, m_p1, m_p2, m_win, m_dir, 1'b0, 1'b0));
            end else if (mr) begin
                if (m_p1 < 4'd3) m_p1 = m_p1 + 4'd1;
                m_dir = 1'b1;
                sb.push_back(pk(3'd4, m_p1, m_p2, m_win, m_dir, 1'b0, 1'b0));
            end else begin
                sb.push_back(pk(3'd2, m_p1, m_p2, m_win, m_dir, 1'b0, 1'b0));
            end
            if (ml ^ mr) begin
                if (m_p1 == 4'd3) begin
                    m_win = 2'b01;
                    sb.push_back(pk(3'd5, m_p1, m_p2, m_win, m_dir, 1'b0, 1'b0));
                end else if (m_p2 == 4'd3) begin
                    m_win = 2'b10;
                    sb.push_back(pk(3'd5, m_p1, m_p2, m_win, m_dir, 1'b0, 1'b0));
                end else begin
                    sb.push_back(pk(3'd1, m_p1, m_p2, m_win, m_dir, 1'b1, 1'b0));
                end
            end
            cyc();
            step_done = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        end
    endtask

    task automatic test_reset();
        int n;
        int period;
        rst_n = 1'b0; start = 1'b1; pause = 1'b0;
        step_done = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        repeat (3) cyc();
        vectors++;
        if (snap() !== 16'h0000 || frame_tick !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold got snap=%h tick=%b ovr=%b expected 0000/0/0", snap(), frame_tick, overrun);
        end
        rst_n = 1'b1;
        repeat (6) cyc();
        vectors++;
        if (state !== 3'd0 || ball_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL held_start got state=%0d br=%b expected 0/0", state, ball_reset);
        end
        start = 1'b0;
        n = 0;
        while (frame_tick !== 1'b1 && n < 10) begin cyc(); n++; end
        cyc();
        period = 1;
        while (frame_tick !== 1'b1 && period < 10) begin cyc(); period++; end
        vectors++;
        if (period != 4) begin
            miscompares++;
            $display("FAIL tick_period got %0d expected 4", period);
        end
    endtask

    task automatic test_start();
        int ticks;
        int n;
        logic [15:0] e;
        reset_dut();
        start = 1'b1;
        sb.push_back(pk(3'd1, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0));
        cyc();
        start = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (snap() !== e) begin
            miscompares++;
            $display("FAIL start_serve got %h expected %h", snap(), e);
        end
        ticks = (frame_tick === 1'b1) ? 1 : 0;
        cyc();
        vectors++;
        if (ball_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL ball_reset_once got %b expected 0", ball_reset);
        end
        n = 0;
        while (state === 3'd1 && n < 40) begin
            if (frame_tick === 1'b1) ticks++;
            cyc();
            n++;
        end
        vectors++;
        if (state !== 3'd2 || ticks != 2) begin
            miscompares++;
            $display("FAIL serve_ticks got state=%0d ticks=%0d expected 2/2", state, ticks);
        end
    endtask

    // Runs from PLAY left by test_start.
    task automatic test_handshake();
        bit ok;
        logic [15:0] e;
        wait_req(20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL hs_req_timeout got step_req=%b expected 1", step_req);
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (step_req !== 1'b1) begin
                miscompares++;
                $display("FAIL hs_hold cycle %0d got %b expected 1", i, step_req);
            end
            cyc();
        end
        step_done = 1'b1;
        sb.push_back(pk(3'd2, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0));
        cyc();
        step_done = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (snap() !== e) begin
            miscompares++;
            $display("FAIL hs_release got %h expected %h", snap(), e);
        end
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL hs_overrun got %b expected 1", overrun);
        end
        cyc();
        vectors++;
        if (step_req !== 1'b0) begin
            miscompares++;
            $display("FAIL hs_no_extra_step got %b expected 0", step_req);
        end
    endtask

    task automatic test_win();
        bit ok;
        bit stray;
        logic [15:0] e;
        reset_dut();
        start_game();
        for (int k = 0; k < 3; k++) begin
            do_step(1'b0, 1'b1, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL win_req_timeout step %0d got step_req=%b expected 1", k, step_req);
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (snap() !== e) begin
                    miscompares++;
                    $display("FAIL win_seq step %0d got %h expected %h", k, snap(), e);
                end
                if (sb.size() > 0) cyc();
            end
        end
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (step_req !== 1'b0 || state !== 3'd5) stray = 1'b1;
        end
        vectors++;
        if (stray) begin
            miscompares++;
            $display("FAIL over_hold got stray activity state=%0d req=%b expected 5/0", state, step_req);
        end
        start = 1'b1;
        sb.push_back(pk(3'd1, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0));
        cyc();
        start = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (snap() !== e) begin
            miscompares++;
            $display("FAIL over_restart got %h expected %h", snap(), e);
        end
    endtask

    task automatic test_double_miss();
        bit ok;
        logic [15:0] e;
        logic [1:0] pat [3];
        pat[0] = 2'b01; pat[1] = 2'b11; pat[2] = 2'b10;
        reset_dut();
        start_game();
        for (int k = 0; k < 3; k++) begin
            do_step(pat[k][1], pat[k][0], ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL dm_req_timeout step %0d got step_req=%b expected 1", k, step_req);
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (snap() !== e) begin
                    miscompares++;
                    $display("FAIL dm_seq step %0d got %h expected %h", k, snap(), e);
                end
                if (sb.size() > 0) cyc();
            end
        end
    endtask

    task automatic test_overrun_pause();
        bit ok;
        int ticks;
        int n;
        reset_dut();
        pause = 1'b1;
        start_game();
        ticks = 0;
        n = 0;
        while (ticks < 10 && n < 80) begin
            if (frame_tick === 1'b1) ticks++;
            cyc();
            n++;
        end
        vectors++;
        if (state !== 3'd1 || ticks != 10) begin
            miscompares++;
            $display("FAIL pause_serve got state=%0d ticks=%0d expected 1/10", state, ticks);
        end
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear got %b expected 0", overrun);
        end
        pause = 1'b0;
        wait_req(60, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL ovr_req_timeout got step_req=%b expected 1", step_req);
        end
        pause = 1'b1;
        repeat (6) cyc();
        vectors++;
        if (overrun !== 1'b1 || step_req !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set got ovr=%b req=%b expected 1/1", overrun, step_req);
        end
        step_done = 1'b1;
        cyc();
        step_done = 1'b0;
        pause = 1'b0;
        vectors++;
        if (step_req !== 1'b0 || state !== 3'd2) begin
            miscompares++;
            $display("FAIL paused_release got req=%b state=%0d expected 0/2", step_req, state);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        reset_dut();
        start_game();
        wait_req(60, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rm_req_timeout got step_req=%b expected 1", step_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (step_req !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_async_drop got %b expected 0", step_req);
        end
        step_done = 1'b1;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (2) cyc();
        vectors++;
        if (snap() !== 16'h0000 || frame_tick !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_after_release got snap=%h tick=%b ovr=%b expected 0000/0/0", snap(), frame_tick, overrun);
        end
        step_done = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_start();
        test_handshake();
        test_win();
        test_double_miss();
        test_overrun_pause();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
